wb_arbiter: RTL
===============

# wb_arbiter

Pipelined Wishbone arbiter that connects `Count` bus masters to one shared slave port. It is the many-to-one counterpart of `wb_multiplexer`, sitting between the CPU's instruction and data masters (and later DMA) and the slave fabric. Ownership is granted round-robin and is held for the owner's whole `cyc` cycle. A watchdog terminates transfers that the slave never acknowledges.

## Interface
- `Count`, 2, number of masters (2..8); index 0 wins the first arbitration after reset.
- `DataWidth`, 32, data width.
- `AddrWidth`, 30, word address width.
- `SelWidth`, DataWidth/8, byte-select width.
- `Timeout`, 255, cycles without ack/err before watchdog fires; 0 disables.

Ports (clock and reset first; `m_*` are unpacked arrays `[Count]`, one per master):
- `clk`  in  1  single clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `m_data_s`  out  DataWidth  read data to each master.
- `m_ack`, `m_stall`, `m_err`  out  1 each  per-master responses.
- `m_data_m`  in  DataWidth  write data from each master.
- `m_addr`  in  AddrWidth  address from each master.
- `m_sel`  in  SelWidth  byte selects from each master.
- `m_cyc`, `m_stb`, `m_we`  in  1 each  per-master requests.
- `s_data_s`  in  DataWidth  slave read data.
- `s_ack`, `s_stall`, `s_err`  in  1 each  slave responses.
- `s_data_m`  out  DataWidth  write data to slave.
- `s_addr`  out  AddrWidth  address to slave.
- `s_sel`  out  SelWidth  byte selects to slave.
- `s_cyc`, `s_stb`, `s_we`  out  1 each  slave requests.

## Operation
- State: `grant_valid`, `owner` ($clog2(Count) bits), `last` (previous owner), `outstanding` counter (0..Count-safe, 8 bits, saturating), `wd` watchdog counter, `aborted` flag.
- IDLE (`!grant_valid`):
  - If any `m_cyc` is high, pick the first requester scanning `last+1, last+2, ... last` modulo Count.
  - Register it into `owner`, set `grant_valid`. `last` updates on grant.
- OWNED (`grant_valid`): the owner's request signals route to `s_*`.
  - `s_cyc = m_cyc[owner] & !aborted`.
  - `s_stb = m_stb[owner] & !aborted`.
  - `s_data_m`, `s_addr`, `s_sel` and `s_we` pass through unconditionally from the owner.
- Owner response path: `m_data_s[owner]=s_data_s`, `m_ack[owner]=s_ack & !aborted`, `m_err[owner]=(s_err & !aborted) | wd_fire`, `m_stall[owner]=s_stall | aborted`.
- Non-owners: `m_stall=1`, `m_ack=0`, `m_err=0`. `m_data_s` is driven with `s_data_s` (don't-care).
- In IDLE, all masters see `m_stall=1`, and `s_cyc=s_stb=0`.
- Release: when `m_cyc[owner]` is low in OWNED, clear `grant_valid` and `aborted` at the next edge. No transfer is forwarded in that cycle.
- `outstanding` changes each cycle:
  - +1 on `s_stb & !s_stall`.
  - -1 on `s_ack | s_err`.
  - Both in the same cycle: no change.
  - Cleared on release or abort.
- Watchdog:
  - `wd` resets to 0 on any ack/err, or when `outstanding==0`. Otherwise it increments.
  - `wd_fire` is a combinational one-cycle pulse when `wd==Timeout-1` and `Timeout!=0`.
  - On fire: set `aborted`, clear `outstanding`. The owner sees a single `m_err`, then `m_stall=1` until it drops `cyc`.
  - Late slave acks after abort are swallowed.
- Bus errors from the slave pass through unchanged and do not release ownership.

## Timing
- Reset values: `grant_valid=0`, `owner=0`, `last=Count-1`, `outstanding=0`, `wd=0`, `aborted=0`.
- Output values during reset: `s_cyc=s_stb=0`, `s_we=0`, all `m_stall=1`, all `m_ack=m_err=0`.
- Grant latency: `m_cyc[i]` rises at cycle N on an idle bus; `s_cyc` rises at N+1. The master's first `stb` is accepted at N+1 at the earliest.
- Handover: owner drops `cyc` at cycle N; the next requester is granted at N+2. This gives one forced idle cycle on `s_cyc`.
- Response path from `s_*` to `m_*` is combinational: zero added latency, one stall bubble at most.
- Simultaneous `m_cyc` from several masters: strict round-robin; no master waits more than Count-1 ownerships.
- Owner drops `cyc` with acks still pending: release anyway and clear `outstanding`. Wishbone forbids this, so it is not a supported protocol case.
- Asynchronous reset mid-transfer: all state clears immediately and outputs go to reset values within the same cycle.

## Test plan
- Single master 0 issues 4 pipelined reads to addresses 0x10..0x13, slave acks 1 cycle later: `s_cyc` rises 1 cycle after `m_cyc[0]`. Master 0 receives 4 acks with the matching data. `m_stall[1]=1` throughout.
- Masters 0 and 1 both raise `cyc` in the same cycle after reset: master 0 is granted first. Master 1 is granted 2 cycles after master 0 drops `cyc`. A third contention grants master 0 again.
- Master 1 writes 0xDEADBEEF with `sel=4'b0011` while master 0 is idle: the slave sees that data, sel and `we=1`, and master 1 receives a single ack.
- With `Timeout=8`, the slave never acks one read: exactly 8 cycles after `stb` acceptance, master 0 sees one `m_err` pulse, then `m_stall=1`. A late `s_ack` is not forwarded, and release follows when `cyc` drops.
- Slave `s_err` on the second of 3 reads: the owner sees err on that beat and acks on the others. Ownership is kept until `cyc` drops.
- Assert `reset_n=0` mid-burst with 2 requests outstanding: `s_cyc` drops immediately and all state returns to reset values. After release, master 0 wins the first arbitration.

Source files
------------

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: Count masters share one slave port.
// The owner keeps the bus for its whole cyc; a watchdog aborts stuck transfers.
//
// state    | meaning
// ST_IDLE  | no owner; all masters stalled, arbitration scans from last+1
// ST_OWNED | owner_q routed to the slave until its cyc drops
module wb_arbiter #(
  parameter int Count     = 2,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 30,
  parameter int SelWidth  = DataWidth / 8,
  parameter int Timeout   = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic [DataWidth-1:0] m_data_s [Count],
  output logic                 m_ack    [Count],
  output logic                 m_stall  [Count],
  output logic                 m_err    [Count],
  input  logic [DataWidth-1:0] m_data_m [Count],
  input  logic [AddrWidth-1:0] m_addr   [Count],
  input  logic [SelWidth-1:0]  m_sel    [Count],
  input  logic                 m_cyc    [Count],
  input  logic                 m_stb    [Count],
  input  logic                 m_we     [Count],
  input  logic [DataWidth-1:0] s_data_s,
  input  logic                 s_ack,
  input  logic                 s_stall,
  input  logic                 s_err,
  output logic [DataWidth-1:0] s_data_m,
  output logic [AddrWidth-1:0] s_addr,
  output logic [SelWidth-1:0]  s_sel,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we
);

  localparam int OwnW = (Count > 1) ? $clog2(Count) : 1;
  localparam int WdW  = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'((Timeout > 0) ? Timeout - 1 : 0);
  localparam logic WdEn = (Timeout != 0);

  typedef enum logic {ST_IDLE, ST_OWNED} state_e;

  state_e          state_q, state_d;
  logic [OwnW-1:0] owner_q, owner_d;
  logic [OwnW-1:0] last_q, last_d;
  logic [7:0]      outst_q, outst_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic            aborted_q, aborted_d;

  logic            owned, own_cyc, wd_fire, accept, resp, found;
  logic [OwnW-1:0] pick, cand_idx;

  // Round-robin scan starting just after the previous owner.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    cand_idx = '0;
    for (int k = 1; k <= Count; k++) begin
      cand_idx = OwnW'((int'(last_q) + k) % Count);
      if (!found && m_cyc[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  // Request path from the owner to the slave, plus watchdog fire.
  always_comb begin
    owned    = (state_q == ST_OWNED);
    own_cyc  = m_cyc[owner_q];
    s_cyc    = owned & own_cyc & ~aborted_q;
    s_stb    = owned & own_cyc & m_stb[owner_q] & ~aborted_q;
    s_we     = owned & m_we[owner_q];
    s_data_m = m_data_m[owner_q];
    s_addr   = m_addr[owner_q];
    s_sel    = m_sel[owner_q];
    wd_fire  = WdEn & owned & ~aborted_q & (outst_q != 8'd0) & (wd_q == WdLast);
    accept   = s_stb & ~s_stall;
    resp     = owned & ~aborted_q & (s_ack | s_err);
  end

  // Response path: only the current owner sees slave handshakes.
  for (genvar g = 0; g < Count; g++) begin : g_resp
    logic is_own;
    assign is_own      = owned & (owner_q == OwnW'(g));
    assign m_data_s[g] = s_data_s;
    assign m_ack[g]    = is_own & s_ack & ~aborted_q;
    assign m_err[g]    = is_own & ((s_err & ~aborted_q) | wd_fire);
    assign m_stall[g]  = ~is_own | s_stall | aborted_q;
  end

  // Next-state: grant, release, outstanding tracking and watchdog.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    outst_d   = outst_q;
    wd_d      = wd_q;
    aborted_d = aborted_q;
    if (state_q == ST_IDLE) begin
      if (found) begin
        state_d   = ST_OWNED;
        owner_d   = pick;
        last_d    = pick;
        outst_d   = 8'd0;
        wd_d      = '0;
        aborted_d = 1'b0;
      end
    end else if (!own_cyc) begin
      state_d   = ST_IDLE;
      aborted_d = 1'b0;
      outst_d   = 8'd0;
      wd_d      = '0;
    end else if (wd_fire) begin
      aborted_d = 1'b1;
      outst_d   = 8'd0;
      wd_d      = '0;
    end else begin
      if (accept && !resp && outst_q != 8'hFF) outst_d = outst_q + 8'd1;
      else if (!accept && resp && outst_q != 8'd0) outst_d = outst_q - 8'd1;
      if (resp || outst_q == 8'd0) wd_d = '0;
      else wd_d = wd_q + WdW'(1);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      last_q    <= OwnW'(Count - 1);
      outst_q   <= 8'd0;
      wd_q      <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      outst_q   <= outst_d;
      wd_q      <= wd_d;
      aborted_q <= aborted_d;
    end
  end

endmodule
